qspi_cmd_arbiter: RTL and testbench
===================================

QSPI_CMD_ARBITER -- requirements
Module: qspi_cmd_arbiter

Interface
REQ-001 Parameter OP_READ, default 8'h03, read opcode.
REQ-002 Parameter OP_PROG, default 8'h02, page-program opcode.
REQ-003 Parameter OP_ERASE, default 8'h20, sector-erase opcode.
REQ-004 Parameter OP_WREN, default 8'h06, write-enable opcode; OP_RDSR, default 8'h05, read-status opcode.
REQ-005 Parameter POLL_MAX, default 1024, status-poll limit (range 1..65535).
REQ-006 clk_i  in  1  clock.
REQ-007 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-008 reqN_valid_i / reqN_ready_o  in/out  1  request handshake for N=0,1.
REQ-009 reqN_type_i  in  4  op type: 0 READ, 1 WRITE, 7 ERASE.
REQ-010 reqN_addr_i, reqN_wdata_i  in  32  address, write data.
REQ-011 rsp_valid_o  out  1; rsp_id_o  out  1; rsp_err_o  out  1; rsp_rdata_o  out  32  response.
REQ-012 seq_start_o  out  1; seq_cmd_type_o  out  4; seq_cmd_o  out  8; seq_addr_o, seq_data_o  out  32  sequencer command.
REQ-013 seq_done_i  in  1; seq_rdata_i  in  32  sequencer completion and read data.

Function
REQ-014 States SHALL be IDLE, WREN, WREN_WAIT, CMD, CMD_WAIT, POLL, POLL_WAIT, RESP.
REQ-015 In IDLE, a request SHALL be accepted (readyN=1 for one cycle, other ready 0) when valid; type, addr, wdata and id latched.
REQ-016 Both valid: round-robin; the requester not granted last SHALL win; after reset req0 has priority.
REQ-017 ready SHALL be 0 outside IDLE; at most one request in flight.
REQ-018 Type not in {0,1,7}: accept, go directly to RESP with rsp_err_o=1, rsp_rdata_o=0; no sequencer traffic.
REQ-019 READ: IDLE->CMD; WRITE/ERASE: IDLE->WREN.
REQ-020 WREN: seq_start_o one-cycle pulse, cmd_type 5, cmd OP_WREN; next WREN_WAIT.
REQ-021 CMD: seq_start_o pulse with cmd_type=latched type, cmd OP_READ/OP_PROG/OP_ERASE, addr, data=wdata; next CMD_WAIT.
REQ-022 *_WAIT SHALL hold until seq_done_i=1; seq_done_i outside a WAIT state ignored.
REQ-023 seq_cmd_type_o, seq_cmd_o, seq_addr_o, seq_data_o SHALL stay stable from start pulse through done.
REQ-024 CMD_WAIT done: READ latches seq_rdata_i, ->RESP; WRITE/ERASE ->POLL (macro on) or RESP (macro off).
REQ-025 POLL: start pulse cmd_type 2, cmd OP_RDSR; POLL_WAIT on done: seq_rdata_i[0]=0 ->RESP; else poll counter+1, ->POLL.
REQ-026 Poll count reaching POLL_MAX with bit0 still 1 ->RESP with rsp_err_o=1.
REQ-027 RESP: rsp_valid_o=1 for exactly one cycle, rsp_id_o=granted id, rdata valid for READ else 0; next IDLE.
REQ-028 Minimum READ latency accept->rsp_valid_o: 3 cycles when seq_done_i arrives one cycle after start.

Reset
REQ-029 Reset SHALL force IDLE, all outputs 0, poll counter 0, round-robin pointer to req0.
REQ-030 Reset mid-operation SHALL abandon the transaction with no response; sequencer handling is external.

Configuration
REQ-031 Macro QSPI_WIP_POLL_EN defined: WRITE/ERASE completion waits on status polling (REQ-025/026).
REQ-032 Macro undefined: POLL states, poll counter and POLL_MAX logic SHALL be absent; WRITE/ERASE respond immediately after CMD done, rsp_err_o=0.

Verification
REQ-033 req0 READ addr 32'h100, seq_rdata_i 32'hCAFEF00D -> one start (type 0, cmd 8'h03), rsp id 0, rdata 32'hCAFEF00D, err 0.
REQ-034 req1 WRITE addr 32'h200 wdata 32'h12345678 -> starts in order type 5/8'h06, type 1/8'h02 data 32'h12345678; with macro, status 1,1,0 -> 3 RDSR starts then rsp id 1 err 0.
REQ-035 Both valid READ continuously -> grants alternate 0,1,0,1; responses ids match.
REQ-036 req0 type 4 -> no seq_start_o, rsp err 1 within 2 cycles.
REQ-037 Macro on, POLL_MAX=4, status bit0 always 1 -> exactly 4 RDSR starts, rsp err 1.
REQ-038 rst_n_i low during CMD_WAIT -> all outputs 0 immediately, no rsp_valid_o after release, next request accepted normally.

Source files
------------

// File: rtl/qspi_cmd_arbiter.sv
// Two-port round-robin arbiter that sequences QSPI flash commands.
// Define QSPI_WIP_POLL_EN to poll WIP after WRITE/ERASE.
module qspi_cmd_arbiter #(
  parameter logic [7:0]  OP_READ  = 8'h03,
  parameter logic [7:0]  OP_PROG  = 8'h02,
  parameter logic [7:0]  OP_ERASE = 8'h20,
  parameter logic [7:0]  OP_WREN  = 8'h06,
  parameter logic [7:0]  OP_RDSR  = 8'h05,
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [3:0]  req0_type_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [3:0]  req1_type_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        seq_start_o,
  output logic [3:0]  seq_cmd_type_o,
  output logic [7:0]  seq_cmd_o,
  output logic [31:0] seq_addr_o,
  output logic [31:0] seq_data_o,
  input  logic        seq_done_i,
  input  logic [31:0] seq_rdata_i
);

  localparam logic [3:0] T_READ  = 4'd0;
  localparam logic [3:0] T_WRITE = 4'd1;
  localparam logic [3:0] T_RDSR  = 4'd2;
  localparam logic [3:0] T_WREN  = 4'd5;
  localparam logic [3:0] T_ERASE = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_WREN_WAIT,
    S_CMD,
    S_CMD_WAIT,
    S_RESP
`ifdef QSPI_WIP_POLL_EN
    ,
    S_POLL,
    S_POLL_WAIT
`endif
  } state_t;

  function automatic logic [7:0] op_of(
    input logic [3:0] t
  );
    logic [7:0] op;
    case (t)
      T_WRITE: op = OP_PROG;
      T_ERASE: op = OP_ERASE;
      T_WREN:  op = OP_WREN;
      T_RDSR:  op = OP_RDSR;
      default: op = OP_READ;
    endcase
    return op;
  endfunction

  state_t      state;
  logic        prio_q;
  logic [3:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

`ifdef QSPI_WIP_POLL_EN
  logic [15:0] poll_cnt_q;
  logic [16:0] poll_nxt;
  logic        poll_lim;

  assign poll_nxt = {1'b0, poll_cnt_q} + 17'd1;
  assign poll_lim = poll_nxt >= 17'(POLL_MAX);
`endif

  logic        gnt_id;
  logic        acc;
  logic        acc_id;
  logic [3:0]  acc_type;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_read;
  logic        acc_legal;

  // prio_q names the requester that wins a tie
  assign gnt_id = (req0_valid_i && req1_valid_i)
                ? prio_q : req1_valid_i;

  assign acc = (state == S_IDLE)
            && ((req0_ready_o && req0_valid_i)
             || (req1_ready_o && req1_valid_i));

  assign acc_id    = req1_ready_o;
  assign acc_type  = acc_id ? req1_type_i  : req0_type_i;
  assign acc_addr  = acc_id ? req1_addr_i  : req0_addr_i;
  assign acc_wdata = acc_id ? req1_wdata_i : req0_wdata_i;
  assign acc_read  = acc_type == T_READ;
  assign acc_legal = acc_read
                  || acc_type == T_WRITE
                  || acc_type == T_ERASE;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      prio_q         <= 1'b0;
      type_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      req0_ready_o   <= 1'b0;
      req1_ready_o   <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_id_o       <= 1'b0;
      rsp_err_o      <= 1'b0;
      rsp_rdata_o    <= '0;
      seq_start_o    <= 1'b0;
      seq_cmd_type_o <= '0;
      seq_cmd_o      <= '0;
      seq_addr_o     <= '0;
      seq_data_o     <= '0;
`ifdef QSPI_WIP_POLL_EN
      poll_cnt_q     <= '0;
`endif
    end else begin
      req0_ready_o <= 1'b0;
      req1_ready_o <= 1'b0;
      seq_start_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc) begin
            type_q      <= acc_type;
            addr_q      <= acc_addr;
            wdata_q     <= acc_wdata;
            prio_q      <= ~acc_id;
            rsp_id_o    <= acc_id;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            if (acc_read) begin
              state          <= S_CMD;
              seq_start_o    <= 1'b1;
              seq_cmd_type_o <= acc_type;
              seq_cmd_o      <= OP_READ;
              seq_addr_o     <= acc_addr;
              seq_data_o     <= acc_wdata;
            end else if (acc_legal) begin
              state          <= S_WREN;
              seq_start_o    <= 1'b1;
              seq_cmd_type_o <= T_WREN;
              seq_cmd_o      <= op_of(T_WREN);
              seq_addr_o     <= '0;
              seq_data_o     <= '0;
            end else begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end
          end else if (!req0_ready_o && !req1_ready_o
                    && (req0_valid_i || req1_valid_i)) begin
            req0_ready_o <= ~gnt_id;
            req1_ready_o <= gnt_id;
          end
        end
        S_WREN: state <= S_WREN_WAIT;
        S_WREN_WAIT: begin
          if (seq_done_i) begin
            state          <= S_CMD;
            seq_start_o    <= 1'b1;
            seq_cmd_type_o <= type_q;
            seq_cmd_o      <= op_of(type_q);
            seq_addr_o     <= addr_q;
            seq_data_o     <= wdata_q;
          end
        end
        S_CMD: state <= S_CMD_WAIT;
        S_CMD_WAIT: begin
          if (seq_done_i) begin
            if (type_q == T_READ) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= seq_rdata_i;
            end else begin
`ifdef QSPI_WIP_POLL_EN
              state          <= S_POLL;
              poll_cnt_q     <= '0;
              seq_start_o    <= 1'b1;
              seq_cmd_type_o <= T_RDSR;
              seq_cmd_o      <= op_of(T_RDSR);
              seq_addr_o     <= '0;
              seq_data_o     <= '0;
`else
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
`endif
            end
          end
        end
`ifdef QSPI_WIP_POLL_EN
        S_POLL: state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (seq_done_i) begin
            if (!seq_rdata_i[0]) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
            end else if (poll_lim) begin
              state       <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              state       <= S_POLL;
              poll_cnt_q  <= poll_nxt[15:0];
              seq_start_o <= 1'b1;
            end
          end
        end
`endif
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_cmd_arbiter.sv
// Self-checking bench for qspi_cmd_arbiter with a one-cycle sequencer model.
// Poll scenarios are built when QSPI_WIP_POLL_EN is defined.
module tb_qspi_cmd_arbiter;

`ifdef QSPI_WIP_POLL_EN
  localparam int PM = 4;
`else
  localparam int PM = 1024;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req0_valid_i, req0_ready_o;
  logic [3:0]  req0_type_i;
  logic [31:0] req0_addr_i, req0_wdata_i;
  logic        req1_valid_i, req1_ready_o;
  logic [3:0]  req1_type_i;
  logic [31:0] req1_addr_i, req1_wdata_i;
  logic        rsp_valid_o, rsp_id_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        seq_start_o;
  logic [3:0]  seq_cmd_type_o;
  logic [7:0]  seq_cmd_o;
  logic [31:0] seq_addr_o, seq_data_o;
  logic        seq_done_i;
  logic [31:0] seq_rdata_i;

  typedef struct packed {
    logic [3:0]  t;
    logic [7:0]  c;
    logic [31:0] a;
    logic [31:0] d;
  } start_t;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  start_t      exp_start_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] rd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int start_cnt = 0;
  int last_rsp_cyc = 0;
  bit seq_mute = 1'b0;

  qspi_cmd_arbiter #(.POLL_MAX(PM)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_type_i(req0_type_i), .req0_addr_i(req0_addr_i),
    .req0_wdata_i(req0_wdata_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_type_i(req1_type_i), .req1_addr_i(req1_addr_i),
    .req1_wdata_i(req1_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
    .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .seq_start_o(seq_start_o), .seq_cmd_type_o(seq_cmd_type_o),
    .seq_cmd_o(seq_cmd_o), .seq_addr_o(seq_addr_o),
    .seq_data_o(seq_data_o),
    .seq_done_i(seq_done_i), .seq_rdata_i(seq_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Sequencer: done (with next queued read word) one cycle after start.
  initial begin
    seq_done_i = 1'b0;
    seq_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (seq_start_o && !seq_mute && rst_n_i) begin
        @(posedge clk_i);
        #1;
        seq_done_i = 1'b1;
        if (rd_q.size() > 0) seq_rdata_i = rd_q.pop_front();
        else seq_rdata_i = '0;
        @(posedge clk_i);
        #1;
        seq_done_i = 1'b0;
        seq_rdata_i = '0;
      end
    end
  end

  start_t cur_start, obs_start, e_start;
  rsp_t   e_rsp;
  bit     prev_rsp = 1'b0;

  always @(negedge clk_i) begin
    obs_start = '{seq_cmd_type_o, seq_cmd_o, seq_addr_o, seq_data_o};
    if (seq_start_o) begin
      start_cnt++;
      cur_start = obs_start;
      checks++;
      if (exp_start_q.size() == 0) begin
        errors++;
        $display("FAIL seq_start unexpected: got %h, required none",
                 obs_start);
      end else begin
        e_start = exp_start_q.pop_front();
        if (obs_start !== e_start) begin
          errors++;
          $display("FAIL seq_start fields: got %h, required %h",
                   obs_start, e_start);
        end
      end
    end
    if (seq_done_i && rst_n_i) begin
      checks++;
      if (obs_start !== cur_start) begin
        errors++;
        $display("FAIL seq_stable: got %h, required %h",
                 obs_start, cur_start);
      end
    end
    if (req0_ready_o || req1_ready_o) begin
      checks++;
      if (req0_ready_o && req1_ready_o) begin
        errors++;
        $display("FAIL ready_onehot: got 2'b11, required one ready");
      end
    end
    if (rsp_valid_o) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      checks++;
      if (exp_rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp unexpected: got id %0d err %0d rdata %h",
                 rsp_id_o, rsp_err_o, rsp_rdata_o);
      end else begin
        e_rsp = exp_rsp_q.pop_front();
        if (rsp_id_o !== e_rsp.id || rsp_err_o !== e_rsp.err
            || rsp_rdata_o !== e_rsp.rdata) begin
          errors++;
          $display("FAIL rsp: got id %0d err %0d rdata %h, required id %0d err %0d rdata %h",
                   rsp_id_o, rsp_err_o, rsp_rdata_o,
                   e_rsp.id, e_rsp.err, e_rsp.rdata);
        end
      end
      checks++;
      if (prev_rsp) begin
        errors++;
        $display("FAIL rsp_pulse: got 2 cycle valid, required 1");
      end
    end
    prev_rsp = rsp_valid_o;
  end

  function automatic logic [113:0] all_outs();
    return {req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o,
            rsp_err_o, rsp_rdata_o, seq_start_o, seq_cmd_type_o,
            seq_cmd_o, seq_addr_o, seq_data_o};
  endfunction

  task automatic send(input bit id, input logic [3:0] t,
                      input logic [31:0] a, input logic [31:0] d,
                      output int acc_cyc);
    @(posedge clk_i);
    #1;
    if (id) begin
      req1_valid_i = 1'b1; req1_type_i = t;
      req1_addr_i = a; req1_wdata_i = d;
    end else begin
      req0_valid_i = 1'b1; req0_type_i = t;
      req0_addr_i = a; req0_wdata_i = d;
    end
    acc_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (id ? req1_ready_o : req0_ready_o) begin
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk_i);
    #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget, output bit to);
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || exp_start_q.size() != 0)
           && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    to = (exp_rsp_q.size() != 0 || exp_start_q.size() != 0);
    exp_rsp_q.delete();
    exp_start_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [113:0] ov;
    rst_n_i = 1'b0;
    req0_valid_i = 1'b1; req0_type_i = 4'd0;
    req0_addr_i = '0; req0_wdata_i = '0;
    req1_valid_i = 1'b0; req1_type_i = 4'd0;
    req1_addr_i = '0; req1_wdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      ov = all_outs();
      checks++;
      if (ov !== '0) begin
        errors++;
        $display("FAIL reset_outs: got %h, required 0", ov);
      end
    end
    req0_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_round_robin();
    int g[4];
    int n, k;
    bit to;
    n = 0; k = 0;
    for (int i = 0; i < 4; i++) begin
      exp_start_q.push_back('{4'd0, 8'h03,
        (i % 2) ? 32'h2000 : 32'h1000, 32'h0});
      rd_q.push_back(32'hA000_0000 + 32'(i));
      exp_rsp_q.push_back('{1'(i % 2), 1'b0,
        32'hA000_0000 + 32'(i)});
    end
    @(posedge clk_i);
    #1;
    req0_valid_i = 1'b1; req0_type_i = 4'd0;
    req0_addr_i = 32'h1000; req0_wdata_i = '0;
    req1_valid_i = 1'b1; req1_type_i = 4'd0;
    req1_addr_i = 32'h2000; req1_wdata_i = '0;
    while (n < 4 && k < 200) begin
      @(negedge clk_i);
      k++;
      if (req0_ready_o) begin g[n] = 0; n++; end
      else if (req1_ready_o) begin g[n] = 1; n++; end
    end
    @(posedge clk_i);
    #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_grants: got %0d, required 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (g[i] != i % 2) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, required %0d",
                 i, g[i], i % 2);
      end
    end
    drain(100, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rr_drain: got timeout, required all responses");
    end
  endtask

  task automatic test_read();
    int acc;
    bit to;
    exp_start_q.push_back('{4'd0, 8'h03, 32'h100, 32'h0});
    rd_q.push_back(32'hCAFE_F00D);
    exp_rsp_q.push_back('{1'b0, 1'b0, 32'hCAFE_F00D});
    send(1'b0, 4'd0, 32'h100, 32'h0, acc);
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL read_accept: got no ready, required ready");
    end
    drain(50, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL read_drain: got timeout, required response");
    end
    checks++;
    if (last_rsp_cyc - acc != 3) begin
      errors++;
      $display("FAIL read_latency: got %0d, required 3",
               last_rsp_cyc - acc);
    end
  endtask

  task automatic test_write();
    int acc, s0, nexp;
    bit to;
    s0 = start_cnt;
    nexp = 2;
    exp_start_q.push_back('{4'd5, 8'h06, 32'h0, 32'h0});
    exp_start_q.push_back('{4'd1, 8'h02, 32'h200, 32'h1234_5678});
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
`ifdef QSPI_WIP_POLL_EN
    nexp = 5;
    rd_q.push_back(32'h1);
    rd_q.push_back(32'h1);
    rd_q.push_back(32'h0);
    for (int i = 0; i < 3; i++)
      exp_start_q.push_back('{4'd2, 8'h05, 32'h0, 32'h0});
`endif
    exp_rsp_q.push_back('{1'b1, 1'b0, 32'h0});
    send(1'b1, 4'd1, 32'h200, 32'h1234_5678, acc);
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL write_accept: got no ready, required ready");
    end
    drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL write_drain: got timeout, required response");
    end
    checks++;
    if (start_cnt - s0 != nexp) begin
      errors++;
      $display("FAIL write_starts: got %0d, required %0d",
               start_cnt - s0, nexp);
    end
  endtask

  task automatic test_erase();
    int acc;
    bit to;
    exp_start_q.push_back('{4'd5, 8'h06, 32'h0, 32'h0});
    exp_start_q.push_back('{4'd7, 8'h20, 32'h3000, 32'hFFFF_0000});
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
`ifdef QSPI_WIP_POLL_EN
    rd_q.push_back(32'h0);
    exp_start_q.push_back('{4'd2, 8'h05, 32'h0, 32'h0});
`endif
    exp_rsp_q.push_back('{1'b0, 1'b0, 32'h0});
    send(1'b0, 4'd7, 32'h3000, 32'hFFFF_0000, acc);
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL erase_accept: got no ready, required ready");
    end
    drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL erase_drain: got timeout, required response");
    end
  endtask

  task automatic test_bad_type();
    int acc, s0;
    bit to;
    s0 = start_cnt;
    exp_rsp_q.push_back('{1'b0, 1'b1, 32'h0});
    send(1'b0, 4'd4, 32'h600, 32'h1, acc);
    drain(20, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bad_drain: got timeout, required response");
    end
    checks++;
    if (start_cnt != s0) begin
      errors++;
      $display("FAIL bad_starts: got %0d, required 0", start_cnt - s0);
    end
    checks++;
    if (acc < 0 || last_rsp_cyc - acc > 2 || last_rsp_cyc <= acc) begin
      errors++;
      $display("FAIL bad_latency: got %0d, required 1..2",
               last_rsp_cyc - acc);
    end
  endtask

`ifdef QSPI_WIP_POLL_EN
  task automatic test_poll_timeout();
    int acc, s0;
    bit to;
    s0 = start_cnt;
    exp_start_q.push_back('{4'd5, 8'h06, 32'h0, 32'h0});
    exp_start_q.push_back('{4'd1, 8'h02, 32'h700, 32'hA5});
    rd_q.push_back(32'h0);
    rd_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(32'h1);
      exp_start_q.push_back('{4'd2, 8'h05, 32'h0, 32'h0});
    end
    exp_rsp_q.push_back('{1'b1, 1'b1, 32'h0});
    send(1'b1, 4'd1, 32'h700, 32'hA5, acc);
    drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL poll_drain: got timeout, required response");
    end
    checks++;
    if (start_cnt - s0 != 6) begin
      errors++;
      $display("FAIL poll_starts: got %0d, required 6", start_cnt - s0);
    end
    repeat (4) @(posedge clk_i);
    #1;
    rd_q.delete();
  endtask
`endif

  task automatic test_reset_mid_op();
    int acc, r0;
    bit to;
    logic [113:0] ov;
    seq_mute = 1'b1;
    r0 = rsp_cnt;
    exp_start_q.push_back('{4'd0, 8'h03, 32'h400, 32'h0});
    send(1'b0, 4'd0, 32'h400, 32'h0, acc);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    ov = all_outs();
    checks++;
    if (ov !== '0) begin
      errors++;
      $display("FAIL midrst_outs: got %h, required 0", ov);
    end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    seq_mute = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    checks++;
    if (rsp_cnt != r0) begin
      errors++;
      $display("FAIL midrst_rsp: got %0d, required 0", rsp_cnt - r0);
    end
    checks++;
    if (exp_start_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_start: got %0d left, required 0",
               exp_start_q.size());
      exp_start_q.delete();
    end
    exp_start_q.push_back('{4'd0, 8'h03, 32'h500, 32'h0});
    rd_q.push_back(32'h5A5A_A5A5);
    exp_rsp_q.push_back('{1'b0, 1'b0, 32'h5A5A_A5A5});
    send(1'b0, 4'd0, 32'h500, 32'h0, acc);
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL midrst_accept: got no ready, required ready");
    end
    drain(50, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL midrst_drain: got timeout, required response");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_write();
    test_erase();
    test_bad_type();
`ifdef QSPI_WIP_POLL_EN
    test_poll_timeout();
`endif
    test_reset_mid_op();
    checks++;
    if (exp_rsp_q.size() != 0 || exp_start_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d/%0d, required 0/0",
               exp_rsp_q.size(), exp_start_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
